// File: rtl/pqcuark_bfu_wb_queue.sv
// Credit-gated result FIFO between the PQC butterfly unit (fixed-latency, non-stalling) and writeback.
// Optional PQCUARK_WBQ_BYPASS_EN: a result arriving at an empty queue with a ready arbiter goes straight out.

module pqcuark_bfu_wb_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PIPE_LAT = 4,
    // Set to $bits(exe_wb_scalar_instr_t) at the instantiation site.
    parameter int unsigned DATA_W   = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic                       res_valid_i,
    input  logic [DATA_W-1:0]          res_data_i,
    output logic                       wb_valid_o,
    output logic [DATA_W-1:0]          wb_data_o,
    input  logic                       wb_ready_i,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic                       overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W:0]    credits_used;
    logic              overflow_q;
    logic              empty, full, bypass, push, pop, do_push, fire;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // Stored plus in-flight results may never exceed the storage, so no arrival can find it full.
    assign credits_used  = {1'b0, count_q} + {1'b0, inflight_q};
    assign issue_ready_o = (credits_used < (CNT_W + 1)'(DEPTH));
    assign fire          = issue_valid_i & issue_ready_o;

`ifdef PQCUARK_WBQ_BYPASS_EN
    assign bypass     = empty & res_valid_i & wb_ready_i & ~flush_i & ~rst_i;
    assign wb_valid_o = ~empty | bypass;
    assign wb_data_o  = bypass ? res_data_i : (empty ? '0 : mem_q[rd_ptr_q]);
`else
    assign bypass     = 1'b0;
    assign wb_valid_o = ~empty;
    assign wb_data_o  = empty ? '0 : mem_q[rd_ptr_q];
`endif

    assign push    = res_valid_i & ~flush_i & ~bypass;
    assign pop     = ~empty & wb_ready_i & ~flush_i;
    assign do_push = push & (~full | pop);

    assign occupancy_o = count_q;
    assign overflow_o  = overflow_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({fire, res_valid_i})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            // Saturate: a result with no recorded credit must not wrap the counter.
            2'b01:   inflight_d = (inflight_q != '0) ? inflight_q - CNT_W'(1) : inflight_q;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            overflow_q <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_d;
            inflight_q <= inflight_d;
            if (push & full & ~pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push & ~rst_i) mem_q[wr_ptr_q] <= res_data_i;
    end

`ifndef SYNTHESIS
    // Raw dispatch history: a result is legitimate if anything entered the pipe PIPE_LAT cycles ago.
    logic [PIPE_LAT-1:0] issue_hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) issue_hist_q <= '0;
        else                  issue_hist_q <= {issue_hist_q[PIPE_LAT-2:0], issue_valid_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(res_valid_i && (inflight_q == '0) && !issue_hist_q[PIPE_LAT-1]))
                else $error("bfu_wb_queue: result arrived with no outstanding issue");
        end
    end
`endif

endmodule
